// File: rtl/i2f_pipe.sv
// i2f_pipe: three-stage pipelined int32 -> IEEE-754 single converter (cvt.s.w),
// round-to-nearest-even, with an inexact flag.
//
// Ports:
//   clk        rising-edge clock
//   clrn       asynchronous active-low reset
//   in_valid   operand on a is valid
//   in_ready   stage 1 can take an operand this cycle
//   a[31:0]    two's-complement operand
//   out_valid  d / p_lost hold a valid result
//   out_ready  downstream takes the result this cycle
//   d[31:0]    {sign, exp[7:0], frac[22:0]}
//   p_lost     result is inexact
//
// Stage | contents
//   S1  | sign, magnitude, zero flag
//   S2  | normalized mantissa, biased exponent
//   S3  | rounded, packed result (drives d / p_lost)
module i2f_pipe (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        p_lost
);

  logic        v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic        ready1, ready2, ready3;

  logic        sign1_q, sign1_d;
  logic [31:0] mag1_q, mag1_d;
  logic        zero1_q, zero1_d;

  logic        sign2_q, sign2_d;
  logic [31:0] m2_q, m2_d;
  logic [7:0]  exp2_q, exp2_d;

  logic [31:0] d_q, d_d;
  logic        p_lost_q, p_lost_d;

  // Position of the highest set bit, expressed as leading-zero count.
  function automatic logic [4:0] count_lz(input logic [31:0] x);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) n = 5'(31 - i);
    end
    return n;
  endfunction

  // Handshake: a stage can take new data when empty or when it is emptying.
  always_comb begin
    ready3 = ~v3_q | out_ready;
    ready2 = ~v2_q | ready3;
    ready1 = ~v1_q | ready2;
    v1_d   = ready1 ? in_valid : v1_q;
    v2_d   = ready2 ? v1_q     : v2_q;
    v3_d   = ready3 ? v2_q     : v3_q;
  end

  // S1: sign / magnitude. -0x80000000 wraps back to 0x80000000, which is
  // exactly the unsigned magnitude wanted.
  always_comb begin
    sign1_d = sign1_q;
    mag1_d  = mag1_q;
    zero1_d = zero1_q;
    if (ready1 && in_valid) begin
      sign1_d = a[31];
      mag1_d  = a[31] ? (~a + 32'd1) : a;
      zero1_d = (a == 32'd0);
    end
  end

  // S2: normalize so the leading one sits at bit 31.
  logic [4:0]  lzc;
  always_comb begin
    lzc     = count_lz(mag1_q);
    sign2_d = sign2_q;
    m2_d    = m2_q;
    exp2_d  = exp2_q;
    if (ready2 && v1_q) begin
      sign2_d = sign1_q;
      m2_d    = mag1_q << lzc;
      exp2_d  = zero1_q ? 8'd0 : (8'd158 - {3'd0, lzc});
    end
  end

  // S3: round to nearest even and pack. After normalization bit 31 of the
  // mantissa is clear only for a zero operand, so it doubles as the zero flag.
  logic        rnd_zero;
  logic [22:0] frac, frac_r;
  logic        lsb, g, s, inc, carry;
  logic [7:0]  exp_r;
  always_comb begin
    rnd_zero        = ~m2_q[31];
    frac            = m2_q[30:8];
    lsb             = m2_q[8];
    g               = m2_q[7];
    s               = |m2_q[6:0];
    inc             = g & (s | lsb);
    {carry, frac_r} = {1'b0, frac} + {23'd0, inc};
    // On carry frac_r has already wrapped to zero.
    exp_r           = carry ? (exp2_q + 8'd1) : exp2_q;
    d_d             = d_q;
    p_lost_d        = p_lost_q;
    if (ready3 && v2_q) begin
      d_d      = rnd_zero ? 32'd0 : {sign2_q, exp_r, frac_r};
      p_lost_d = rnd_zero ? 1'b0  : (g | s);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      sign1_q  <= 1'b0;
      mag1_q   <= 32'd0;
      zero1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      m2_q     <= 32'd0;
      exp2_q   <= 8'd0;
      d_q      <= 32'd0;
      p_lost_q <= 1'b0;
    end else begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      sign1_q  <= sign1_d;
      mag1_q   <= mag1_d;
      zero1_q  <= zero1_d;
      sign2_q  <= sign2_d;
      m2_q     <= m2_d;
      exp2_q   <= exp2_d;
      d_q      <= d_d;
      p_lost_q <= p_lost_d;
    end
  end

  assign in_ready  = ready1;
  assign out_valid = v3_q;
  assign d         = d_q;
  assign p_lost    = p_lost_q;

endmodule

// File: tb/tb_i2f_pipe.sv
// Bench for i2f_pipe: directed corners, back-pressure, random traffic against
// an arithmetic reference model, and asynchronous reset with data in flight.
module tb_i2f_pipe;

  logic        clk = 1'b0;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        p_lost;

  int n_checks = 0;
  int n_errors = 0;

  logic [32:0] sb[$];
  bit          hold_pend = 0;
  logic [31:0] hold_d;
  logic        hold_p;

  i2f_pipe dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .p_lost    (p_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: exact magnitude, pick the leading bit, round the quotient by
  // comparing the remainder with half an ulp. Returns {inexact, word}.
  function automatic logic [32:0] ref_cvt(input logic [31:0] x);
    longint unsigned m, q, rem, half;
    int e, sh;
    logic sgn;
    logic [7:0] ex;
    logic [22:0] fr;
    if (x == 32'd0) return 33'd0;
    sgn = x[31];
    m = {32'd0, x};
    if (sgn) m = 64'h1_0000_0000 - m;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    rem = 0;
    if (e <= 23) q = m << (23 - e);
    else begin
      sh = e - 23;
      q = m >> sh;
      rem = m & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    ex = 8'(127 + e);
    fr = q[22:0];
    return {rem != 0, sgn, ex, fr};
  endfunction

  function automatic logic [31:0] gen_operand();
    logic [31:0] x;
    int sh;
    case ($urandom_range(0, 3))
      0: x = $urandom;
      1: x = $urandom >> $urandom_range(0, 31);
      2: x = $urandom_range(0, 1023);
      default: begin
        // Force an exact half-ulp remainder to exercise ties.
        sh = $urandom_range(1, 8);
        x = $urandom >> (8 - sh);
        x = (x & ~((32'd1 << sh) - 32'd1)) | (32'd1 << (sh - 1));
        x = x | (32'h8000_0000 >> (8 - sh));
      end
    endcase
    if ($urandom_range(0, 1) == 1) x = -x;
    return x;
  endfunction

  // Transfers are judged at the falling edge; they take effect at the next rise.
  always @(negedge clk) begin
    logic [32:0] e;
    if (clrn === 1'b1) begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_d", d, hold_d);
        chk("hold_p", 32'(p_lost), 32'(hold_p));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_d", d, e[31:0]);
          chk("sb_p_lost", 32'(p_lost), 32'(e[32]));
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_cvt(a));
      hold_pend = out_valid & ~out_ready;
      hold_d    = d;
      hold_p    = p_lost;
    end
  end

  // Single operand with out_ready high; latency counted in edges from accept.
  task automatic run_single(input string tag, input logic [31:0] val,
                            input logic [31:0] exp_d, input logic exp_p);
    int cnt;
    a = val;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 32'd3);
    chk({tag, "_d"}, d, exp_d);
    chk({tag, "_p"}, 32'(p_lost), 32'(exp_p));
  endtask

  initial begin
    logic [31:0] bp_vals[4];
    logic [31:0] bp_exp[4];
    int          idx, acc, cyc;
    bit          fire, pending;
    logic [31:0] cur;

    bp_vals = '{32'd1, 32'd2, 32'd3, 32'd4};
    bp_exp  = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};

    clrn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 32'd0;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_d", d, 32'd0);
    chk("rst_p_lost", 32'(p_lost), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    clrn = 1'b1;
    @(posedge clk); #1;

    run_single("one",     32'd1,          32'h3F80_0000, 1'b0);
    run_single("m_one",   32'hFFFF_FFFF,  32'hBF80_0000, 1'b0);
    run_single("zero",    32'd0,          32'h0000_0000, 1'b0);
    run_single("int_min", 32'h8000_0000,  32'hCF00_0000, 1'b0);
    run_single("int_max", 32'h7FFF_FFFF,  32'h4F00_0000, 1'b1);
    run_single("tie_even",32'h0100_0001,  32'h4B80_0000, 1'b1);
    run_single("tie_odd", 32'h0100_0003,  32'h4B80_0002, 1'b1);
    run_single("exact24", 32'h00FF_FFFF,  32'h4B7F_FFFF, 1'b0);
    @(posedge clk); #1;

    // Back-pressure: fill with out_ready low, fourth operand must wait.
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      a = bp_vals[idx];
      in_valid = 1'b1;
      #1;
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) begin
        acc++;
        if (idx < 3) idx++;
      end
    end
    chk("bp_accepts", acc, 32'd3);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk("bp_stall_d", d, 32'h3F80_0000);
      chk("bp_stall_valid", 32'(out_valid), 32'd1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_full_shift_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_d", d, bp_exp[i]);
      @(posedge clk); #1;
      if (i == 0) in_valid = 1'b0;
    end
    chk("bp_empty", 32'(out_valid), 32'd0);

    // Random traffic; an offered operand is held until accepted.
    acc = 0;
    cyc = 0;
    pending = 0;
    cur = 32'd0;
    while (acc < 10000 && cyc < 60000) begin
      if (!pending) cur = gen_operand();
      in_valid = pending || ($urandom_range(0, 9) < 7);
      a = cur;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      fire = in_valid & in_ready;
      @(posedge clk); #1;
      if (fire) begin
        acc++;
        pending = 0;
      end else pending = in_valid;
      cyc++;
    end
    chk("rand_accepts", acc, 32'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) begin
      @(posedge clk); #1;
    end
    chk("rand_drained", sb.size(), 32'd0);

    // Asynchronous reset with three operands in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1234_0000 + 32'(i);
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("arst_pre_valid", 32'(out_valid), 32'd1);
    chk("arst_pre_in_ready", 32'(in_ready), 32'd0);
    #2;
    clrn = 1'b0;
    sb.delete();
    hold_pend = 0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_d", d, 32'd0);
    chk("arst_p_lost", 32'(p_lost), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); #2;
    clrn = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("arst_stale", 32'(out_valid), 32'd0);
    end
    run_single("post_rst", 32'hFFFF_FFFE, 32'hC000_0000, 1'b0);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
